// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constant sets and colour-bar helpers
package vga_timing_pkg;

    // 640x480@60, 25.175 MHz pixel clock, negative syncs
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_H_ACT   = 640;
    localparam int VGA_H_FRONT = 16;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;
    localparam int VGA_V_ACT   = 480;
    localparam int VGA_V_FRONT = 10;

    // 800x600@60, 40 MHz pixel clock, positive syncs
    localparam int SVGA_H_SYNC  = 128;
    localparam int SVGA_H_BACK  = 88;
    localparam int SVGA_H_ACT   = 800;
    localparam int SVGA_H_FRONT = 40;
    localparam int SVGA_V_SYNC  = 4;
    localparam int SVGA_V_BACK  = 23;
    localparam int SVGA_V_ACT   = 600;
    localparam int SVGA_V_FRONT = 1;

    localparam int BAR_COUNT = 8;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    // Returns {r,g,b} on/off flags for a bar position, left to right.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (bar_e'(idx))
            BAR_WHITE:   bar_rgb = 3'b111;
            BAR_YELLOW:  bar_rgb = 3'b110;
            BAR_CYAN:    bar_rgb = 3'b011;
            BAR_GREEN:   bar_rgb = 3'b010;
            BAR_MAGENTA: bar_rgb = 3'b101;
            BAR_RED:     bar_rgb = 3'b100;
            BAR_BLUE:    bar_rgb = 3'b001;
            default:     bar_rgb = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen_p_if.sv
// rtl/vga_timing_gen_p_if.sv - pixel request / host colour bundle between display logic and timing generator
interface vga_timing_gen_p_if #(
    parameter int COLOR_W = 10,
    parameter int CNT_W   = 11
);
    logic               oRequest;
    logic [CNT_W-1:0]   oReq_X;
    logic [CNT_W-1:0]   oReq_Y;
    logic [COLOR_W-1:0] iRed;
    logic [COLOR_W-1:0] iGreen;
    logic [COLOR_W-1:0] iBlue;

    modport master (
        output oRequest, oReq_X, oReq_Y,
        input  iRed, iGreen, iBlue
    );

    modport slave (
        input  oRequest, oReq_X, oReq_Y,
        output iRed, iGreen, iBlue
    );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - modulo-TOTAL counter for one scan axis, wrap flags the advancing last count
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CNT_W = 11
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iAdv,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        wrap    = iAdv && (count_q == LAST);
        count_d = count_q;
        if (iAdv) begin
            count_d = wrap ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/vga_timing_gen_p.sv
// rtl/vga_timing_gen_p.sv - parametrised VGA timing generator with prefetch request and DAC colour gating
// Optional: define VGA_TEST_PATTERN_EN to replace host colour with eight vertical colour bars.
module vga_timing_gen_p
    import vga_timing_pkg::*;
#(
    parameter int COLOR_W    = 10,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int H_ACT      = VGA_H_ACT,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int V_ACT      = VGA_V_ACT,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int REQ_LEAD   = 2,
    parameter int CNT_W      = 11
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    vga_timing_gen_p_if.master pix,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK,
    output logic               oFrame_Start,
    output logic               oLine_Start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int X_START = H_SYNC + H_BACK;
    localparam int Y_START = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] X_START_C = CNT_W'(X_START);
    localparam logic [CNT_W-1:0] X_END_C   = CNT_W'(X_START + H_ACT);
    localparam logic [CNT_W-1:0] Y_START_C = CNT_W'(Y_START);
    localparam logic [CNT_W-1:0] Y_END_C   = CNT_W'(Y_START + V_ACT);
    // One extra bit so the lookahead never wraps near the end of a line.
    localparam logic [CNT_W:0]   LEAD_L    = (CNT_W+1)'(REQ_LEAD);
    localparam logic [CNT_W:0]   X_START_L = (CNT_W+1)'(X_START);
    localparam logic [CNT_W:0]   X_END_L   = (CNT_W+1)'(X_START + H_ACT);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_wrap;
    logic             v_wrap_unused;

    vga_axis_counter #(.TOTAL(H_TOTAL), .CNT_W(CNT_W)) u_h_cnt (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iAdv   (1'b1),
        .count  (h),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .CNT_W(CNT_W)) u_v_cnt (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iAdv   (h_wrap),
        .count  (v),
        .wrap   (v_wrap_unused)
    );

    logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic               req_q, req_d, fs_q, fs_d, ls_q, ls_d;
    logic [CNT_W-1:0]   req_x_q, req_x_d, req_y_q, req_y_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    logic               v_act, act, req_act;
    logic [CNT_W:0]     h_lead;
`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACT / BAR_COUNT;
    logic [CNT_W-1:0]   x_act;
    logic [2:0]         bar;
    logic [2:0]         rgb;
`endif

    always_comb begin
        v_act   = (v >= Y_START_C) && (v < Y_END_C);
        act     = (h >= X_START_C) && (h < X_END_C) && v_act;
        h_lead  = {1'b0, h} + LEAD_L;
        req_act = (h_lead >= X_START_L) && (h_lead < X_END_L) && v_act;

        hs_d    = (h < H_SYNC_C) ? H_SYNC_POL : ~H_SYNC_POL;
        vs_d    = (v < V_SYNC_C) ? V_SYNC_POL : ~V_SYNC_POL;
        blank_d = act;
        fs_d    = (h == '0) && (v == '0);
        ls_d    = (h == '0);
        req_d   = req_act;
        req_x_d = req_act ? (h_lead[CNT_W-1:0] - X_START_C) : '0;
        req_y_d = req_act ? (v - Y_START_C) : '0;

`ifdef VGA_TEST_PATTERN_EN
        x_act = h - X_START_C;
        bar   = 3'd0;
        for (int i = 1; i < BAR_COUNT; i++) begin
            if (x_act >= CNT_W'(i * BAR_W)) begin
                bar = 3'(i);
            end
        end
        rgb = bar_rgb(bar);
        r_d = (act && rgb[2]) ? '1 : '0;
        g_d = (act && rgb[1]) ? '1 : '0;
        b_d = (act && rgb[0]) ? '1 : '0;
`else
        r_d = act ? pix.iRed   : '0;
        g_d = act ? pix.iGreen : '0;
        b_d = act ? pix.iBlue  : '0;
`endif
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            hs_q    <= ~H_SYNC_POL;
            vs_q    <= ~V_SYNC_POL;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            req_q   <= 1'b0;
            req_x_q <= '0;
            req_y_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            req_q   <= req_d;
            req_x_q <= req_x_d;
            req_y_q <= req_y_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign pix.oRequest = req_q;
    assign pix.oReq_X   = req_x_q;
    assign pix.oReq_Y   = req_y_q;
    assign oVGA_R       = r_q;
    assign oVGA_G       = g_q;
    assign oVGA_B       = b_q;
    assign oVGA_H_SYNC  = hs_q;
    assign oVGA_V_SYNC  = vs_q;
    assign oVGA_BLANK   = blank_q;
    assign oVGA_SYNC    = 1'b0;
    assign oVGA_CLOCK   = iCLK;
    assign oFrame_Start = fs_q;
    assign oLine_Start  = ls_q;
endmodule
